// File: rtl/sum_accumulator.sv
// Frame accumulator: sums FRAME_LEN accepted samples, then holds the total until the sink takes it.
// Optional SUM_ACC_SAT_EN clamps the running total to all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned ACC_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               ovf_any;
    logic [ACC_W-1:0]   acc_add;
    logic               last;

    // One extra bit captures the carry out of the accumulator's MSB.
    assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(sum_in);
    assign ovf_any = ovf_q | sum_ext[ACC_W];
    assign last    = (cnt_q == CNT_W'(FRAME_LEN - 1));

`ifdef SUM_ACC_SAT_EN
    assign acc_add = ovf_any ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    assign in_ready  = (state_q == ACCUM) & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign frame_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Flush wins over a coincident sample; HOLD ignores both inputs until the sink handshakes.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACCUM: begin
                if (flush) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (last) begin
                        out_data_d  = acc_add;
                        out_ovf_d   = ovf_any;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        ovf_d       = 1'b0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = acc_add;
                        ovf_d = ovf_any;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator with a queue-based frame model; ACC_W=9 so overflow is frequent.
module tb_sum_accumulator;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned ACC_W     = 9;
    localparam int          MAXV      = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sum_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic [7:0]        frame_cnt;

    sum_accumulator #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_in   (sum_in),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: samples of the open frame, plus the presented result.
    int q_samples[$];
    bit m_hold;
    bit m_out_valid;
    int m_out_data;
    bit m_out_ovf;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_samples.delete();
        m_hold      = 1'b0;
        m_out_valid = 1'b0;
        m_out_data  = 0;
        m_out_ovf   = 1'b0;
    endtask

    task automatic model_close_frame();
        int total = 0;
        foreach (q_samples[i]) total += q_samples[i];
        m_out_ovf = (total > MAXV);
`ifdef SUM_ACC_SAT_EN
        m_out_data = m_out_ovf ? MAXV : total;
`else
        m_out_data = total % (MAXV + 1);
`endif
        m_out_valid = 1'b1;
        m_hold      = 1'b1;
        q_samples.delete();
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (!m_hold) begin
            if (flush) begin
                q_samples.delete();
            end else if (in_valid) begin
                q_samples.push_back(int'(sum_in));
                if (q_samples.size() == FRAME_LEN) model_close_frame();
            end
        end else if (out_ready) begin
            m_hold      = 1'b0;
            m_out_valid = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, advance the model on the edge, return at the following negedge.
    task automatic drive(input bit v, input int s, input bit f, input bit r);
        in_valid  = v;
        sum_in    = DATA_W'(s);
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d, input bit r);
        drive(1, a, 0, 1);
        drive(1, b, 0, 1);
        drive(1, c, 0, 1);
        drive(1, d, 0, r);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            cmp("in_ready", int'(in_ready), int'(!rst && !m_hold));
            cmp("out_valid", int'(out_valid), int'(m_out_valid));
            cmp("frame_cnt", int'(frame_cnt), q_samples.size());
            if (m_out_valid) begin
                cmp("out_data", int'(out_data), m_out_data);
                cmp("out_ovf", int'(out_ovf), int'(m_out_ovf));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; sum_in = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        cmp("rst_out_valid", int'(out_valid), 0);
        cmp("rst_out_data", int'(out_data), 0);
        cmp("rst_out_ovf", int'(out_ovf), 0);
        cmp("rst_frame_cnt", int'(frame_cnt), 0);
        cmp("rst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Basic frame, immediate handshake.
        frame4(10, 15, 25, 200, 1);
        cmp("f1_valid", int'(out_valid), 1);
        cmp("f1_data", int'(out_data), 250);
        cmp("f1_ovf", int'(out_ovf), 0);
        cmp("f1_in_ready", int'(in_ready), 0);
        drive(0, 0, 0, 1);
        cmp("f1_done_valid", int'(out_valid), 0);
        cmp("f1_done_ready", int'(in_ready), 1);

        // Backpressure: extra samples must be refused while holding.
        frame4(10, 15, 25, 200, 0);
        repeat (5) drive(1, 99, 0, 0);
        cmp("bp_valid", int'(out_valid), 1);
        cmp("bp_data", int'(out_data), 250);
        cmp("bp_in_ready", int'(in_ready), 0);
        cmp("bp_cnt", int'(frame_cnt), 0);
        drive(1, 99, 0, 1);
        frame4(1, 2, 3, 4, 1);
        cmp("f2_data", int'(out_data), 10);
        drive(0, 0, 0, 1);

        // Overflow on a 9-bit accumulator.
        frame4(255, 255, 255, 255, 1);
`ifdef SUM_ACC_SAT_EN
        cmp("ovf_data", int'(out_data), 511);
`else
        cmp("ovf_data", int'(out_data), 508);
`endif
        cmp("ovf_flag", int'(out_ovf), 1);
        drive(0, 0, 0, 1);

        // Flush beats a coincident sample.
        drive(1, 7, 0, 1);
        drive(1, 9, 0, 1);
        cmp("pre_flush_cnt", int'(frame_cnt), 2);
        drive(1, 50, 1, 1);
        cmp("flush_cnt", int'(frame_cnt), 0);
        frame4(1, 2, 3, 4, 1);
        cmp("flush_data", int'(out_data), 10);
        cmp("flush_ovf", int'(out_ovf), 0);
        drive(0, 0, 0, 1);

        // Asynchronous reset mid-frame.
        drive(1, 100, 0, 1);
        drive(1, 100, 0, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        cmp("arst_cnt", int'(frame_cnt), 0);
        cmp("arst_valid", int'(out_valid), 0);
        cmp("arst_data", int'(out_data), 0);
        cmp("arst_in_ready", int'(in_ready), 0);
        #1 rst = 1'b0;
        frame4(5, 5, 5, 5, 1);
        cmp("arst_f_data", int'(out_data), 20);
        drive(0, 0, 0, 1);

        // Flush while holding must not lose the pending total.
        frame4(10, 10, 10, 10, 0);
        drive(0, 0, 1, 0);
        drive(1, 3, 1, 0);
        cmp("hflush_valid", int'(out_valid), 1);
        cmp("hflush_data", int'(out_data), 40);
        drive(0, 0, 1, 1);
        cmp("hflush_released", int'(out_valid), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end
        drive(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
